booth_mult_pipe: RTL and testbench
==================================

Name: booth_mult_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiplier for the datapath arithmetic library. Generalises the 32-bit combinational Booth/compressor-tree/Kogge-Stone multiplier.
- Adds: any even width N, per-transaction signed/unsigned mode, three register stages, and a valid/ready handshake with full backpressure.
- Sits between operand-issue logic and the result writeback path; accepts one operation per cycle.

Parameters:
- N, 32, operand width in bits; must be even and >= 4.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on in_a/in_b/in_signed/in_tag are valid.
- in_ready  output  1  block can accept the operation this cycle.
- in_a  input  N  multiplicand.
- in_b  input  N  multiplier (Booth-recoded operand).
- in_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  input  TAG_W  passed unchanged to out_tag.
- out_valid  output  1  out_p/out_tag hold a completed product.
- out_ready  input  1  consumer accepts the product this cycle.
- out_p  output  2N  exact product.
- out_tag  output  TAG_W  tag of the operation on out_p.
- occupancy  output  2  number of valid stages (0..3).

Behaviour:
- Reset: all stage valid bits 0, out_valid 0, out_p 0, out_tag 0, occupancy 0. Reset is asynchronous and acts immediately. Deasserting rst_n mid-operation discards all in-flight operations; none reappear after reset.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- S1 register (operand capture and Booth recode):
  - Operands are extended to N+2 bits: sign-extended if in_signed, zero-extended otherwise.
  - The multiplier is recoded into N/2+1 radix-4 digits in {-2,-1,0,+1,+2}.
  - Partial products (with negation increment bits) and in_tag are registered.
- S2 register: the 5:3 compressor / full-adder tree reduces the partial products to sum and carry vectors of 2N bits each, which are registered.
- S3 register (output):
  - A 2N-bit parallel-prefix add of sum and carry, carry-in 0, is registered into out_p.
  - Carry-out and bits above 2N are discarded; the result is exact modulo 2^(2N).
  - out_valid equals the S3 valid bit.
- Latency: 3 cycles from input transfer to out_valid, with out_ready held 1.
- Throughput: 1 operation per cycle.
- Stall rules:
  - Stage k advances if it is empty or stage k+1 advances.
  - S3 advances if it is empty or out_ready is 1.
  - in_ready = S1 advances; it is combinational from out_ready through the stall chain.
- Bubbles: internal bubbles collapse. An empty stage accepts new data even while downstream stages are stalled.
- Hold stability: while out_valid=1 and out_ready=0, out_p and out_tag are held stable.
- Empty output: when out_valid=0, out_p and out_tag keep their last values (no required value).
- Simultaneous input and output transfer in the same cycle with a full pipeline is legal; occupancy stays 3.
- Occupancy = S1 valid + S2 valid + S3 valid, updated every clock.
- Corner cases that must be exact:
  - Signed: (-2^(N-1)) x (-2^(N-1)) = 2^(2N-2).
  - Unsigned: (2^N-1)^2.
  - Zero operands give 0.
- in_signed is sampled per transaction; mixed-mode back-to-back operations are legal.

Test Plan:
- N=32, unsigned, A=10, B=10, out_ready=1 → out_valid 3 cycles later, out_p=100, out_tag echoed.
- Signed, A=-25, B=1000 → out_p=0xFFFFFFFFFFFF9E58 (-25000). Next cycle, signed A=-25, B=-21 → out_p=525. Results arrive on consecutive cycles.
- Unsigned A=B=0xFFFFFFFF → 0xFFFFFFFE00000001. Signed A=B=0x80000000 → 0x4000000000000000. Same operands issued unsigned → 0x4000000000000000. Signed A=0xFFFFFFFF, B=1 → 0xFFFFFFFFFFFFFFFF.
- Backpressure:
  - Stream 5 ops with out_ready=0 → in_ready drops after 3 accepts; occupancy=3; out_p stable.
  - Raise out_ready → remaining ops drain in order, tags 0..4, none lost or duplicated.
- Bubble collapse: issue ops on cycles 0 and 2 with out_ready=0 → both captured; occupancy reaches 2 without in_ready deasserting.
- Assert rst_n=0 with 3 ops in flight → out_valid, occupancy and out_p are 0 immediately. After release, no stale result appears; a new op 7x6 yields 42.
- Randomised: N=8 and N=16 builds, 10k random signed/unsigned ops with random out_ready → every product matches the reference model, in order.

Source files
------------

// File: rtl/booth_mult_pipe.sv
// Pipelined radix-4 Booth multiplier with per-operation signed/unsigned mode.
// Three register stages: Booth partial products, carry-save sum/carry, final product.
module booth_mult_pipe #(
  parameter int N     = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       occupancy
);

  localparam int ND = N / 2 + 1;
  localparam int W  = 2 * N;

  // Handshake: a transfer happens on a rising edge where valid && ready. A
  // stage moves forward when it is empty or its successor moves forward, so
  // in_ready is combinational from out_ready and empty stages absorb bubbles.
  logic s1_v, s2_v, s3_v;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv    = !s3_v || out_ready;
  assign s2_adv    = !s2_v || s3_adv;
  assign s1_adv    = !s1_v || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s3_v;
  assign occupancy = {1'b0, s1_v} + {1'b0, s2_v} + {1'b0, s3_v};

  // Booth recoding of the (N+2)-bit extended multiplier into ND digits.
  logic [N+2:0]   bz;
  logic [N+2:0]   a1, a2;
  logic [2:0]     trip;
  logic [N+2:0]   mag;
  logic           neg;
  logic [W-1:0]   row;
  logic [W-1:0]   pp_c [ND];
  logic [ND-1:0]  neg_c;

  always_comb begin
    bz   = {{2{in_signed & in_b[N-1]}}, in_b, 1'b0};
    a1   = {{3{in_signed & in_a[N-1]}}, in_a};
    a2   = a1 << 1;
    trip = '0;
    mag  = '0;
    neg  = 1'b0;
    row  = '0;
    for (int i = 0; i < ND; i++) begin
      trip = bz[2*i +: 3];
      case (trip)
        3'b001, 3'b010: begin mag = a1; neg = 1'b0; end
        3'b011:         begin mag = a2; neg = 1'b0; end
        3'b100:         begin mag = a2; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a1; neg = 1'b1; end
        default:        begin mag = '0; neg = 1'b0; end
      endcase
      row = {{(N-3){mag[N+2]}}, mag};
      if (neg) row = ~row;
      pp_c[i]  = row << (2 * i);
      neg_c[i] = neg;
    end
  end

  logic [W-1:0]     s1_pp [ND];
  logic [ND-1:0]    s1_neg;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_neg <= '0;
      s1_tag <= '0;
      for (int i = 0; i < ND; i++) s1_pp[i] <= '0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_neg <= neg_c;
        s1_tag <= in_tag;
        for (int i = 0; i < ND; i++) s1_pp[i] <= pp_c[i];
      end
    end
  end

  // Carry-save reduction of all rows plus the negation increment bits.
  logic [W-1:0] negv, cs_s, cs_c, cs_t;

  always_comb begin
    negv = '0;
    for (int i = 0; i < ND; i++) negv[2*i] = s1_neg[i];
    cs_s = negv;
    cs_c = '0;
    cs_t = '0;
    for (int i = 0; i < ND; i++) begin
      cs_t = cs_s ^ cs_c ^ s1_pp[i];
      cs_c = ((cs_s & cs_c) | (cs_s & s1_pp[i]) | (cs_c & s1_pp[i])) << 1;
      cs_s = cs_t;
    end
  end

  logic [W-1:0]     s2_sum, s2_carry;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sum   <= cs_s;
        s2_carry <= cs_c;
        s2_tag   <= s1_tag;
      end
    end
  end

  // Kogge-Stone prefix carries; g/p hold group generate/propagate spans.
  logic [W-1:0] ks_x, ks_g, ks_p, ks_sum;

  always_comb begin
    ks_x = s2_sum ^ s2_carry;
    ks_g = s2_sum & s2_carry;
    ks_p = ks_x;
    for (int d = 1; d < W; d = d * 2) begin
      ks_g = ks_g | (ks_p & (ks_g << d));
      ks_p = ks_p & (ks_p << d);
    end
    ks_sum = ks_x ^ {ks_g[W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v    <= 1'b0;
      out_p   <= '0;
      out_tag <= '0;
    end else if (s3_adv) begin
      s3_v <= s2_v;
      if (s2_v) begin
        out_p   <= ks_sum;
        out_tag <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Self-checking bench for booth_mult_pipe: directed corners, backpressure,
// bubble and reset scenarios, then randomized traffic against a product model.
module tb_booth_mult_pipe;

  localparam int N     = 32;
  localparam int TAG_W = 4;
  localparam int W     = 2 * N;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_p;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;

  booth_mult_pipe #(.N(N), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .occupancy(occupancy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  int last_lat = 0;
  bit rnd_mode = 0;

  logic [W-1:0]     exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  int               acc_q[$];
  logic [W-1:0]     got_q[$];
  logic [TAG_W-1:0] got_tag_q[$];
  int               got_cyc_q[$];

  task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference product: extend both operands to 2N bits and multiply.
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic s);
    logic [W-1:0] ea, eb;
    ea = s ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
    eb = s ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
    return ea * eb;
  endfunction

  // scoreboard: in-flight count, readiness and every valid output vs the model
  always @(negedge clk) begin
    if (rst_n) begin
      ncyc++;
      chk(int'(occupancy) == exp_q.size(), "occupancy", W'(occupancy), W'(exp_q.size()));
      chk(in_ready == (exp_q.size() < 3 || out_ready), "in_ready", W'(in_ready),
          W'(exp_q.size() < 3 || out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", out_p, '0);
        end else begin
          chk(out_p == exp_q[0], "out_p", out_p, exp_q[0]);
          chk(out_tag == tag_q[0], "out_tag", W'(out_tag), W'(tag_q[0]));
          if (out_ready) begin
            last_lat = ncyc - acc_q[0];
            chk(last_lat >= 3, "latency_min", W'(last_lat), W'(3));
            got_q.push_back(out_p);
            got_tag_q.push_back(out_tag);
            got_cyc_q.push_back(ncyc);
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_signed));
        tag_q.push_back(in_tag);
        acc_q.push_back(ncyc);
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks: all called at posedge+1
  task automatic present(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                         input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = tag;
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [TAG_W-1:0] tag);
    bit acc;
    int k;
    present(a, b, s, tag);
    acc = 0;
    k = 0;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
    if (!acc) chk(1'b0, "issue_timeout", W'(k), W'(200));
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(exp_q.size() == 0, "drain_timeout", W'(exp_q.size()), '0);
  endtask

  function automatic logic [N-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(N-1){1'b0}}};
      3: return N'(1);
      default: return r[N-1:0];
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i, n, sz, k;
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_tag = '0; out_ready = 1'b0;

    // model pinned to hand-computed products
    chk(model(32'd10, 32'd10, 1'b0) == 64'd100, "model_10x10", model(32'd10, 32'd10, 1'b0), 64'd100);
    chk(model(32'hFFFFFFE7, 32'd1000, 1'b1) == 64'hFFFFFFFFFFFF9E58, "model_neg25x1000",
        model(32'hFFFFFFE7, 32'd1000, 1'b1), 64'hFFFFFFFFFFFF9E58);
    chk(model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0) == 64'hFFFFFFFE00000001, "model_umax",
        model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE00000001);
    chk(model(32'h80000000, 32'h80000000, 1'b1) == 64'h4000000000000000, "model_smin",
        model(32'h80000000, 32'h80000000, 1'b1), 64'h4000000000000000);

    repeat (2) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", W'(out_valid), '0);
    chk(out_p == '0, "rst_out_p", out_p, '0);
    chk(out_tag == '0, "rst_out_tag", W'(out_tag), '0);
    chk(occupancy == 2'd0, "rst_occupancy", W'(occupancy), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic latency
    out_ready = 1'b1;
    issue(32'd10, 32'd10, 1'b0, 4'd5);
    wait_drain(20);
    sz = got_q.size();
    chk(sz >= 1 && got_q[sz-1] == 64'd100, "p_10x10", got_q[sz-1], 64'd100);
    chk(got_tag_q[sz-1] == 4'd5, "tag_10x10", W'(got_tag_q[sz-1]), W'(5));
    chk(last_lat == 3, "latency", W'(last_lat), W'(3));

    // signed pair, back to back
    issue(32'hFFFFFFE7, 32'd1000, 1'b1, 4'd1);
    issue(32'hFFFFFFE7, 32'hFFFFFFEB, 1'b1, 4'd2);
    wait_drain(20);
    sz = got_q.size();
    chk(got_q[sz-2] == 64'hFFFFFFFFFFFF9E58, "p_neg25x1000", got_q[sz-2], 64'hFFFFFFFFFFFF9E58);
    chk(got_q[sz-1] == 64'd525, "p_neg25xneg21", got_q[sz-1], 64'd525);
    chk(got_cyc_q[sz-1] - got_cyc_q[sz-2] == 1, "consecutive", W'(got_cyc_q[sz-1] - got_cyc_q[sz-2]), W'(1));

    // corner operands
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd3);
    issue(32'h80000000, 32'h80000000, 1'b1, 4'd4);
    issue(32'h80000000, 32'h80000000, 1'b0, 4'd6);
    issue(32'hFFFFFFFF, 32'd1, 1'b1, 4'd7);
    issue(32'd0, 32'hFFFFFFFF, 1'b1, 4'd8);
    wait_drain(20);
    sz = got_q.size();
    chk(got_q[sz-5] == 64'hFFFFFFFE00000001, "p_umax", got_q[sz-5], 64'hFFFFFFFE00000001);
    chk(got_q[sz-4] == 64'h4000000000000000, "p_smin", got_q[sz-4], 64'h4000000000000000);
    chk(got_q[sz-3] == 64'h4000000000000000, "p_umsb", got_q[sz-3], 64'h4000000000000000);
    chk(got_q[sz-2] == 64'hFFFFFFFFFFFFFFFF, "p_neg1x1", got_q[sz-2], 64'hFFFFFFFFFFFFFFFF);
    chk(got_q[sz-1] == 64'd0, "p_zero", got_q[sz-1], 64'd0);

    // backpressure: five ops into a stalled pipe
    out_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 8; c++) begin
      if (i < 5) present(N'(i + 3), N'(i + 7), 1'b0, TAG_W'(i));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
    end
    chk(i == 3, "bp_accepts", W'(i), W'(3));
    @(negedge clk);
    chk(in_ready == 1'b0, "bp_in_ready", W'(in_ready), '0);
    chk(occupancy == 2'd3, "bp_occupancy", W'(occupancy), W'(3));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = got_q.size();
    k = 0;
    while (i < 5 && k < 50) begin
      present(N'(i + 3), N'(i + 7), 1'b0, TAG_W'(i));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      k++;
    end
    in_valid = 1'b0;
    chk(i == 5, "bp_all_accepted", W'(i), W'(5));
    wait_drain(20);
    chk(got_q.size() - n == 5, "bp_drain_count", W'(got_q.size() - n), W'(5));
    for (int j = 0; j < 5; j++)
      chk(got_tag_q[n+j] == TAG_W'(j), "bp_tag_order", W'(got_tag_q[n+j]), W'(j));

    // bubble collapse
    out_ready = 1'b0;
    present(32'd11, 32'd13, 1'b0, 4'd1);
    @(negedge clk);
    chk(in_ready == 1'b1, "bubble_acc0", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    present(32'hFFFFFFF0, 32'd3, 1'b1, 4'd2);
    @(negedge clk);
    chk(in_ready == 1'b1, "bubble_acc2", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk(occupancy == 2'd2, "bubble_occupancy", W'(occupancy), W'(2));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain(20);

    // asynchronous reset with three ops in flight
    out_ready = 1'b0;
    issue(32'd5, 32'd9, 1'b0, 4'd1);
    issue(32'd6, 32'd9, 1'b0, 4'd2);
    issue(32'd7, 32'd9, 1'b0, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "arst_out_valid", W'(out_valid), '0);
    chk(occupancy == 2'd0, "arst_occupancy", W'(occupancy), '0);
    chk(out_p == '0, "arst_out_p", out_p, '0);
    exp_q.delete();
    tag_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n = got_q.size();
    issue(32'd7, 32'd6, 1'b0, 4'd9);
    wait_drain(20);
    chk(got_q.size() == n + 1, "post_rst_count", W'(got_q.size()), W'(n + 1));
    chk(got_q[got_q.size()-1] == 64'd42, "p_7x6", got_q[got_q.size()-1], 64'd42);

    // randomized traffic with random backpressure
    rnd_mode = 1;
    for (int r = 0; r < 10000; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)));
    end
    rnd_mode = 0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
